fir_tap_sequencer: RTL and testbench

Time-multiplexed controller for the FIR datapath. It accepts one SIZE-bit sample per valid/ready handshake and keeps a NUM_COEFF-deep sample history and coefficient bank. A single shared multiplier-accumulator evaluates y[n] = sum c[k]*x[n-k], one tap per cycle. The result is presented on a valid/ready output port. It sits between the top-level pin wrapper (samples on uio_in, coefficients on ui_in fields) and the output drive (uio_out).

---
 rtl/fir_tap_sequencer.sv | 147 ++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one shared MAC, one tap per cycle.
// Ports: clk/rst_n; in_* sample handshake; cfg_* coefficient writes;
// flush clears history; y_out/out_valid/out_ready result handshake;
// busy flags a computation in flight.
module fir_tap_sequencer #(
  parameter int SIZE      = 8,
  parameter int NUM_COEFF = 4,
  parameter int SHIFT     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SIZE-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_COEFF)-1:0] cfg_sel,
  input  logic [SIZE-1:0]              cfg_data,
  output logic                         cfg_ready,
  input  logic                         flush,
  output logic [SIZE-1:0]              y_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int SW = $clog2(NUM_COEFF);
  localparam int AW = 2*SIZE + SW;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0] hist_q  [NUM_COEFF];
  logic [SIZE-1:0] hist_d  [NUM_COEFF];
  logic [SIZE-1:0] coeff_q [NUM_COEFF];
  logic [SIZE-1:0] coeff_d [NUM_COEFF];

  logic [AW-1:0]     acc_q, acc_d;
  logic [SW-1:0]     tap_q, tap_d;
  logic [SIZE-1:0]   y_q, y_d;
  logic              ov_q, ov_d;

  logic [2*SIZE-1:0] prod;
  logic [AW-1:0]     acc_sum;
  logic [AW-1:0]     res;
  logic [SIZE-1:0]   sat;
  logic              accept;
  logic              cfg_take;

  localparam logic [AW-1:0] MAXV =
    {{(AW-SIZE){1'b0}}, {SIZE{1'b1}}};

  // Handshake outputs are forced low while reset is held.
  assign in_ready  = rst_n & (state_q == IDLE) & ~flush;
  assign cfg_ready = rst_n & (state_q == IDLE);
  assign busy      = rst_n & (state_q != IDLE);
  assign y_out     = y_q;
  assign out_valid = ov_q;

  assign accept   = in_valid & in_ready;
  assign cfg_take = cfg_we & cfg_ready;

  // Accumulator is wide enough that the full sum never wraps.
  always_comb begin
    prod    = coeff_q[tap_q] * hist_q[tap_q];
    acc_sum = acc_q + {{SW{1'b0}}, prod};
    res     = acc_sum >> SHIFT;
    if (res > MAXV) sat = {SIZE{1'b1}};
    else            sat = res[SIZE-1:0];
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    coeff_d = coeff_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    y_d     = y_q;
    ov_d    = ov_q;

    if (cfg_take && (32'(cfg_sel) < NUM_COEFF))
      coeff_d[cfg_sel] = cfg_data;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          for (int k = 0; k < NUM_COEFF; k++)
            hist_d[k] = '0;
        end else if (accept) begin
          for (int k = NUM_COEFF-1; k > 0; k--)
            hist_d[k] = hist_q[k-1];
          hist_d[0] = in_data;
          acc_d     = '0;
          tap_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (tap_q == SW'(NUM_COEFF-1)) begin
          tap_d   = '0;
          y_d     = sat;
          ov_d    = 1'b1;
          state_d = OUT;
        end else begin
          tap_d = tap_q + SW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) begin
        hist_q[k]  <= '0;
        coeff_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      for (int k = 0; k < NUM_COEFF; k++) begin
        hist_q[k]  <= hist_d[k];
        coeff_q[k] <= coeff_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (SHIFT=0 and SHIFT=8 instances
// share all inputs).
module tb_fir_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       flush;
  logic       out_ready;

  logic       in_ready, cfg_ready, out_valid, busy;
  logic [7:0] y_out;
  logic       in_ready8, cfg_ready8, out_valid8, busy8;
  logic [7:0] y8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.SIZE(8), .NUM_COEFF(4), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .flush(flush),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  fir_tap_sequencer #(.SIZE(8), .NUM_COEFF(4), .SHIFT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready8),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready8), .flush(flush),
    .y_out(y8), .out_valid(out_valid8), .out_ready(out_ready),
    .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE.
  task automatic wr_coeff(input logic [1:0] k, input logic [7:0] v);
    cfg_we   = 1'b1;
    cfg_sel  = k;
    cfg_data = v;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  // mode 0: plain; 1: cfg write c0=9 on accept edge; 2: same write in MAC.
  // Returns at the negedge where out_valid is first seen.
  task automatic do_sample(input logic [7:0] d, input int mode,
                           output logic [7:0] y, output logic [7:0] ys,
                           output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_data  = d;
    in_valid = 1'b1;
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd9;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
    cfg_we   = 1'b0;
    lat      = 0;
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd9;
      chk("cfg_ready_in_mac", 32'(cfg_ready), 32'd0);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    y  = y_out;
    ys = y8;
  endtask

  logic [7:0] y, ys;
  int lat;
  logic [7:0] exp_seq [4];

  initial begin
    exp_seq[0] = 8'd10; exp_seq[1] = 8'd40;
    exp_seq[2] = 8'd100; exp_seq[3] = 8'd200;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y_out", 32'(y_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    wr_coeff(2'd0, 8'd1);
    wr_coeff(2'd1, 8'd2);
    wr_coeff(2'd2, 8'd3);
    wr_coeff(2'd3, 8'd4);
    for (int i = 0; i < 4; i++) begin
      do_sample(8'(10*(i+1)), 0, y, ys, lat);
      chk("seq_y", 32'(y), 32'(exp_seq[i]));
      chk("seq_latency", 32'(lat), 32'd4);
    end

    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_no_accept", 32'(busy), 32'd0);
    do_sample(8'd5, 0, y, ys, lat);
    chk("flush_y", 32'(y), 32'd5);

    @(negedge clk);
    out_ready = 1'b0;
    do_sample(8'd6, 0, y, ys, lat);
    chk("bp_first_y", 32'(y), 32'd16);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'(100 + i*7);
      @(negedge clk);
      chk("bp_y_stable", 32'(y_out), 32'd16);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(out_valid), 32'd0);
    do_sample(8'd1, 0, y, ys, lat);
    chk("bp_history", 32'(y), 32'd28);

    do_sample(8'd2, 2, y, ys, lat);
    chk("gate_mac_y", 32'(y), 32'd42);
    do_sample(8'd3, 0, y, ys, lat);
    chk("gate_old_coeff", 32'(y), 32'd34);
    do_sample(8'd4, 1, y, ys, lat);
    chk("gate_idle_write", 32'(y), 32'd52);

    @(negedge clk);
    for (int k = 0; k < 4; k++)
      wr_coeff(2'(k), 8'd31);
    do_flush();
    for (int i = 0; i < 4; i++) begin
      do_sample(8'd255, 0, y, ys, lat);
      if (i == 0) begin
        chk("sat_first_s0", 32'(y), 32'd255);
        chk("sat_first_s8", 32'(ys), 32'd30);
      end else if (i == 3) begin
        chk("sat_fourth_s0", 32'(y), 32'd255);
        chk("sat_fourth_s8", 32'(ys), 32'd123);
      end
    end

    @(negedge clk);
    in_data  = 8'd77;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_y", 32'(y_out), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_ov", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    wr_coeff(2'd0, 8'd1);
    wr_coeff(2'd1, 8'd0);
    wr_coeff(2'd2, 8'd0);
    wr_coeff(2'd3, 8'd0);
    do_sample(8'd7, 0, y, ys, lat);
    chk("post_rst_y", 32'(y), 32'd7);
    chk("post_rst_latency", 32'(lat), 32'd4);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
